// File: rtl/demux16_tdm_deser_if.sv
// demux16_tdm_deser_if: serial TDM input and deserialized frame output bundle
interface demux16_tdm_deser_if;
  logic        din;
  logic        din_valid;
  logic        frame_sync;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [3:0]  slot;
  logic        locked;
  logic        sync_err;
  logic        overrun;
  modport master (
    output din, din_valid, frame_sync, dout_ready,
    input  dout, dout_valid, slot, locked, sync_err, overrun
  );
  modport slave (
    input  din, din_valid, frame_sync, dout_ready,
    output dout, dout_valid, slot, locked, sync_err, overrun
  );
endinterface

// File: rtl/demux16_tdm_deser.sv
// demux16_tdm_deser: 1:16 TDM deserializer with frame alignment and a registered valid/ready output
module demux16_tdm_deser (
  input logic             clk,
  input logic             rst,
  demux16_tdm_deser_if.slave bus
);
  typedef enum logic {HUNT, LOCK} state_t;
  state_t      state_q, state_d;
  logic [3:0]  slot_q, slot_d;
  logic [14:0] shadow_q, shadow_d;
  logic [15:0] dout_q, dout_d;
  logic        dv_q, dv_d, serr_q, serr_d, ovr_q, ovr_d;
  // Register all state; reset drops any partial frame and pending output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      slot_q   <= '0;
      shadow_q <= '0;
      dout_q   <= '0;
      dv_q     <= 1'b0;
      serr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
      serr_q   <= serr_d;
      ovr_q    <= ovr_d;
    end
  end
  // Route each beat to its slot, re-align on misplaced sync, hand completed frames to the output stage
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    dv_d     = dv_q && !bus.dout_ready;
    serr_d   = 1'b0;
    ovr_d    = 1'b0;
    if (bus.din_valid) begin
      if (state_q == HUNT) begin
        if (bus.frame_sync) begin
          state_d  = LOCK;
          shadow_d = {14'd0, bus.din};
          slot_d   = 4'd1;
        end
      end else if (bus.frame_sync && slot_q != 4'd0) begin
        serr_d   = 1'b1;
        shadow_d = {14'd0, bus.din};
        slot_d   = 4'd1;
      end else if (slot_q == 4'd15) begin
        slot_d = 4'd0;
        if (!dv_q || bus.dout_ready) begin
          dout_d = {bus.din, shadow_q};
          dv_d   = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else begin
        shadow_d = (shadow_q & ~(15'd1 << slot_q)) | (15'(bus.din) << slot_q);
        slot_d   = slot_q + 4'd1;
      end
    end
  end
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.slot       = slot_q;
  assign bus.locked     = state_q == LOCK;
  assign bus.sync_err   = serr_q;
  assign bus.overrun    = ovr_q;
endmodule
